// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: data width, ALU opcode encoding and
// the sequencer FSM state encoding.
package alu_sequencer_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_A = 3'd5,
    ALU_PASS_B = 3'd6,
    ALU_NOT    = 3'd7
  } enum_alu_opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } enum_seq_state_t;

endpackage

// File: rtl/seq_regfile.sv
// Register file for the ALU sequencer: one write port, three combinational
// read ports (rs1, rs2, debug); register 0 always reads zero.
module seq_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 8,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rs1_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [AW-1:0]         rs2_addr,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [AW-1:0]         dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [2:0][AW-1:0]         rd_addr;
  logic [2:0][DATA_WIDTH-1:0] rd_data;

  // Entry 0 is reset to zero and never written, so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_reg <= '{default: '0};
    end else if (wr_en && (wr_addr != '0)) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_addr = {dbg_addr, rs2_addr, rs1_addr};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rd_port
      assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 : regs_reg[rd_addr[gi]];
    end
  endgenerate

  assign {dbg_data, rs2_data, rs1_data} = rd_data;

endmodule

// File: rtl/alu_sequencer.sv
// Issues one instruction at a time to an external ALU: registers operands,
// waits ALU_LATENCY cycles, captures result/flags and writes back.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int ALU_LATENCY = 1,
  parameter int FLAG_WIDTH  = 3,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  enum_alu_opcode_t      instr_opcode,
  input  logic                  instr_mode,
  input  logic [AW-1:0]         instr_rd,
  input  logic [AW-1:0]         instr_rs1,
  input  logic [AW-1:0]         instr_rs2,
  input  logic                  instr_use_imm,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  input  logic                  instr_use_carry,
  output logic [DATA_WIDTH-1:0] alu_in_a,
  output logic [DATA_WIDTH-1:0] alu_in_b,
  output logic                  alu_input_carry,
  output enum_alu_opcode_t      alu_opcode,
  output logic                  alu_mode,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [FLAG_WIDTH-1:0] alu_out_flag,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [FLAG_WIDTH-1:0] flags,
  input  logic [AW-1:0]         dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(ALU_LATENCY - 1);

  enum_seq_state_t state_reg, state_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic                  accept, capture, writeback;

  logic [DATA_WIDTH-1:0] a_reg, b_reg, result_reg;
  logic                  carry_reg, mode_reg, done_reg;
  enum_alu_opcode_t      opcode_reg;
  logic [AW-1:0]         rd_reg;
  logic [FLAG_WIDTH-1:0] flag_hold_reg, flags_reg;
  logic [DATA_WIDTH-1:0] rs1_data, rs2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    accept      = 1'b0;
    capture     = 1'b0;
    writeback   = 1'b0;
    instr_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          capture    = 1'b1;
          state_next = WB;
        end
      end
      WB: begin
        writeback  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU-facing registers only change on accept, so they stay valid in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      opcode_reg    <= ALU_ADD;
      mode_reg      <= 1'b0;
      rd_reg        <= '0;
      result_reg    <= '0;
      flag_hold_reg <= '0;
      flags_reg     <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= writeback;
      if (accept) begin
        a_reg      <= rs1_data;
        b_reg      <= instr_use_imm ? instr_imm : rs2_data;
        carry_reg  <= instr_use_carry & flags_reg[0];
        opcode_reg <= instr_opcode;
        mode_reg   <= instr_mode;
        rd_reg     <= instr_rd;
      end
      if (capture) begin
        result_reg    <= alu_out;
        flag_hold_reg <= alu_out_flag;
      end
      if (writeback) begin
        flags_reg <= flag_hold_reg;
      end
    end
  end

  seq_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (writeback),
    .wr_addr  (rd_reg),
    .wr_data  (result_reg),
    .rs1_addr (instr_rs1),
    .rs1_data (rs1_data),
    .rs2_addr (instr_rs2),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign alu_in_a        = a_reg;
  assign alu_in_b        = b_reg;
  assign alu_input_carry = carry_reg;
  assign alu_opcode      = opcode_reg;
  assign alu_mode        = mode_reg;
  assign done            = done_reg;
  assign result          = result_reg;
  assign flags           = flags_reg;

endmodule
